// File: rtl/exins_arbiter.sv
// Shares one single-ported instruction memory between core fetches and loader writes.
// Optional fetch/load watchdog with sticky bus_err: define EXINS_ARB_TIMEOUT_EN.
module exins_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int MAX_LD_BURST = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              exIns_ren,
    input  logic [31:0]       exIns_addr,
    output logic              exIns_valid,
    output logic [31:0]       exIns_in,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic [1:0] state;
    logic [3:0] burst_cnt;
    logic       pick_ld, pick_fe, forced, done;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{exIns_addr[31:ADDR_W+2], exIns_addr[1:0],
                                ld_addr[31:ADDR_W+2], ld_addr[1:0]};

    // Loader wins unless it has already taken MAX_LD_BURST grants over a waiting core.
    always_comb begin
        pick_ld = ld_req && (!exIns_ren || (burst_cnt < 4'(MAX_LD_BURST)));
        pick_fe = exIns_ren && !pick_ld;
    end

`ifdef EXINS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    assign forced = (state != S_IDLE) && !mem_ready && (tmo_cnt == TW'(TIMEOUT));

    // Cleared every IDLE cycle, so it reads 0 in the mem_en cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            if (state == S_IDLE)
                tmo_cnt <= '0;
            else if (tmo_cnt != TW'(TIMEOUT))
                tmo_cnt <= tmo_cnt + 1'b1;
            if (forced)
                bus_err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign forced  = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign done = (state != S_IDLE) && (mem_ready || forced);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IDLE;
            burst_cnt   <= '0;
            exIns_valid <= 1'b0;
            exIns_in    <= '0;
            ld_gnt      <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            mem_en      <= 1'b0;
            exIns_valid <= 1'b0;
            ld_gnt      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_ld) begin
                        state     <= S_LOAD;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= ld_addr[ADDR_W+1:2];
                        mem_wdata <= ld_wdata;
                    end else if (pick_fe) begin
                        state     <= S_FETCH;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= exIns_addr[ADDR_W+1:2];
                        mem_wdata <= '0;
                    end
                end
                S_FETCH: begin
                    if (done) begin
                        exIns_in    <= forced ? NOP : mem_rdata;
                        exIns_valid <= 1'b1;
                        burst_cnt   <= '0;
                        state       <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (done) begin
                        ld_gnt <= 1'b1;
                        mem_we <= 1'b0;
                        state  <= S_IDLE;
                        if (!exIns_ren)
                            burst_cnt <= '0;
                        else if (burst_cnt != 4'hF)
                            burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exins_arbiter.sv
// Directed bench for exins_arbiter: fetch, load, burst fairness, reset abort, request drop, timeout.
module tb_exins_arbiter;
    logic        clk = 1'b0;
    logic        nrst;
    logic        exIns_ren;
    logic [31:0] exIns_addr;
    logic        exIns_valid;
    logic [31:0] exIns_in;
    logic        ld_req;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_gnt;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    int total = 0;
    int bad   = 0;
    int mem_wait = 0;
    logic [31:0] mem_val = 32'h0;

    exins_arbiter #(.ADDR_W(10), .MAX_LD_BURST(4), .TIMEOUT(8)) dut (
        .clk(clk), .nrst(nrst),
        .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
        .exIns_valid(exIns_valid), .exIns_in(exIns_in),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Memory model: mem_ready arrives mem_wait cycles after the cycle following mem_en; -1 never responds.
    initial begin
        int pend;
        pend = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (!nrst) pend = 0;
            else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        mem_ready = 1'b1;
                        mem_rdata = mem_val;
                    end
                end
                if (mem_en && mem_wait >= 0) pend = mem_wait + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] seq;
        int ne, nf, nl, hits;

        nrst = 1'b0; exIns_ren = 1'b0; exIns_addr = 32'h0;
        ld_req = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
        tick(); tick();
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_valid", {31'h0, exIns_valid}, 32'h0);
        chk("rst_gnt", {31'h0, ld_gnt}, 32'h0);
        chk("rst_exins_in", exIns_in, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        nrst = 1'b1;
        tick();

        // Zero-wait fetch at word 'hCA
        mem_wait = 0; mem_val = 32'h0000_0013;
        exIns_ren = 1'b1; exIns_addr = 32'h0000_0328;
        chk("f1_no_en_at_N", {31'h0, mem_en}, 32'h0);
        tick();
        chk("f1_mem_en", {31'h0, mem_en}, 32'h1);
        chk("f1_mem_we", {31'h0, mem_we}, 32'h0);
        chk("f1_mem_addr", {22'h0, mem_addr}, 32'h0CA);
        tick();
        chk("f1_en_pulse", {31'h0, mem_en}, 32'h0);
        chk("f1_valid_early", {31'h0, exIns_valid}, 32'h0);
        tick();
        chk("f1_valid", {31'h0, exIns_valid}, 32'h1);
        chk("f1_data", exIns_in, 32'h0000_0013);
        exIns_ren = 1'b0;
        tick();
        chk("f1_valid_pulse", {31'h0, exIns_valid}, 32'h0);

        // Loader write with a 3-cycle wait memory
        mem_wait = 3;
        ld_req = 1'b1; ld_addr = 32'h0000_0010; ld_wdata = 32'hDEAD_BEEF;
        tick();
        chk("l1_mem_en", {31'h0, mem_en}, 32'h1);
        chk("l1_mem_we", {31'h0, mem_we}, 32'h1);
        chk("l1_mem_addr", {22'h0, mem_addr}, 32'h4);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_wdata !== 32'hDEAD_BEEF || ld_gnt !== 1'b0) hits++;
        end
        chk("l1_wdata_held", hits, 0);
        tick();
        chk("l1_gnt", {31'h0, ld_gnt}, 32'h1);
        ld_req = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ld_gnt) hits++;
        end
        chk("l1_gnt_once", hits, 0);

        // Both requesters continuously high: L,L,L,L,F repeating
        mem_wait = 0; mem_val = 32'hCAFE_0001;
        exIns_ren = 1'b1; exIns_addr = 32'h0000_0020;
        ld_req = 1'b1; ld_addr = 32'h0000_0100; ld_wdata = 32'h5555_AAAA;
        seq = '0; ne = 0; nf = 0; nl = 0;
        for (int i = 0; i < 200 && (nf + nl) < 10; i++) begin
            tick();
            if (mem_en && ne < 10) begin
                seq[ne] = mem_we;
                ne++;
            end
            if (exIns_valid) nf++;
            if (ld_gnt) nl++;
        end
        exIns_ren = 1'b0; ld_req = 1'b0;
        chk("burst_completions", nf + nl, 10);
        chk("burst_fetches", nf, 2);
        chk("burst_seq", {22'h0, seq}, {22'h0, 10'b0111101111});
        tick(); tick();

        // Reset two cycles after mem_en of a fetch the memory never answers
        mem_wait = -1;
        exIns_ren = 1'b1; exIns_addr = 32'h0000_0040;
        tick();
        chk("r_mem_en", {31'h0, mem_en}, 32'h1);
        tick(); tick();
        nrst = 1'b0;
        #1;
        chk("r_mem_addr0", {22'h0, mem_addr}, 32'h0);
        chk("r_mem_we0", {31'h0, mem_we}, 32'h0);
        chk("r_exins_in0", exIns_in, 32'h0);
        exIns_ren = 1'b0;
        tick();
        nrst = 1'b1;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (exIns_valid || mem_en) hits++;
        end
        chk("r_no_pulse", hits, 0);

        // Fetch whose request drops one cycle after mem_en
        mem_wait = 2; mem_val = 32'h1234_5678;
        exIns_ren = 1'b1; exIns_addr = 32'h0000_0100;
        tick();
        chk("d_mem_addr", {22'h0, mem_addr}, 32'h040);
        tick();
        exIns_ren = 1'b0;
        tick();
        chk("d_valid_early1", {31'h0, exIns_valid}, 32'h0);
        tick();
        chk("d_valid_early2", {31'h0, exIns_valid}, 32'h0);
        tick();
        chk("d_valid", {31'h0, exIns_valid}, 32'h1);
        chk("d_data", exIns_in, 32'h1234_5678);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (exIns_valid || mem_en) hits++;
        end
        chk("d_idle_after", hits, 0);

`ifdef EXINS_ARB_TIMEOUT_EN
        // Unanswered fetch forced to NOP after TIMEOUT cycles
        mem_wait = -1;
        exIns_ren = 1'b1; exIns_addr = 32'h0000_0008;
        tick();
        chk("t_mem_en", {31'h0, mem_en}, 32'h1);
        hits = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (exIns_valid) hits++;
        end
        chk("t_no_early_valid", hits, 0);
        tick();
        chk("t_valid", {31'h0, exIns_valid}, 32'h1);
        chk("t_nop", exIns_in, 32'h0000_0013);
        chk("t_bus_err", {31'h0, bus_err}, 32'h1);
        exIns_ren = 1'b0;
        tick(); tick(); tick();
        chk("t_bus_err_sticky", {31'h0, bus_err}, 32'h1);
        nrst = 1'b0;
        #1;
        chk("t_bus_err_rst", {31'h0, bus_err}, 32'h0);
        tick();
        nrst = 1'b1;
`else
        chk("no_tmo_bus_err", {31'h0, bus_err}, 32'h0);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
